// File: rtl/uart_baud_gen.sv
// Fractional baud-rate generator for the UART TX/RX engines.
// An integer+fraction divisor sets the os_tick period; every OVS-th os_tick
// is also a bit_tick, and div_clk is a 50% square wave at the bit rate.
// Divisor writes are staged in a pending register and take effect on a
// period boundary so a running frame never sees a torn period.
module uart_baud_gen #(
   parameter int CNT_W  = 16,
   parameter int FRAC_W = 4,
   parameter int OVS    = 16
) (
   input  logic              HRESET,
   input  logic              CLK,
   input  logic              enable,
   input  logic [CNT_W-1:0]  div_int,
   input  logic [FRAC_W-1:0] div_frac,
   input  logic              div_load,
   input  logic              restart,
   output logic              os_tick,
   output logic              bit_tick,
   output logic              div_clk,
   output logic              cfg_err
);

   // OVS is expected to be even and within 4..16.
   localparam int OS_W = (OVS > 1) ? $clog2(OVS) : 1;

   localparam logic [CNT_W-1:0] DIV_MIN  = CNT_W'(2);
   localparam logic [CNT_W:0]   CNT_ONE  = (CNT_W+1)'(1);
   localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVS - 1);
   localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVS / 2);
   localparam logic [OS_W-1:0]  OS_ONE   = OS_W'(1);

   // Divisor registers
   logic [CNT_W-1:0]  act_int;
   logic [FRAC_W-1:0] act_frac;
   logic [CNT_W-1:0]  pend_int;
   logic [FRAC_W-1:0] pend_frac;
   logic              pend_valid;

   // Timing state; the cycle counter is one bit wider so D+carry always fits
   logic [CNT_W:0]    cnt;
   logic [FRAC_W-1:0] acc;
   logic              carry;
   logic [OS_W-1:0]   os_cnt;

   // Derived combinational values
   logic [CNT_W-1:0]  d_eff;
   logic [CNT_W:0]    last_cnt;
   logic              wrap;
   logic              apply;
   logic [FRAC_W:0]   acc_sum;
   logic              os_last;
   logic [OS_W-1:0]   os_next;
   logic              div_clk_next;

   // Effective divisor, period end detection and next-value arithmetic
   always_comb begin
      d_eff        = (act_int < DIV_MIN) ? DIV_MIN : act_int;
      // Last count of the period is D-1+carry, i.e. D when a carry stretches it.
      last_cnt     = {1'b0, d_eff} - {{CNT_W{1'b0}}, ~carry};
      // '>=' rather than '==' so a divisor shrunk while frozen cannot strand
      // the counter above the new terminal count.
      wrap         = enable && (cnt >= last_cnt);
      apply        = pend_valid && (restart || !enable || wrap);
      acc_sum      = {1'b0, acc} + {1'b0, act_frac};
      os_last      = (os_cnt == OS_LAST);
      os_next      = os_last ? '0 : (os_cnt + OS_ONE);
      div_clk_next = (os_next < OS_HALF);
   end

   // Pending/active divisor double buffer; a load coinciding with restart
   // goes straight to active since restart applies pending immediately.
   always_ff @(posedge CLK or negedge HRESET) begin
      if (!HRESET) begin
         act_int    <= DIV_MIN;
         act_frac   <= '0;
         pend_int   <= DIV_MIN;
         pend_frac  <= '0;
         pend_valid <= 1'b0;
      end else if (restart && div_load) begin
         act_int    <= div_int;
         act_frac   <= div_frac;
         pend_int   <= div_int;
         pend_frac  <= div_frac;
         pend_valid <= 1'b0;
      end else begin
         if (apply) begin
            act_int    <= pend_int;
            act_frac   <= pend_frac;
            pend_valid <= 1'b0;
         end
         if (div_load) begin
            pend_int   <= div_int;
            pend_frac  <= div_frac;
            pend_valid <= 1'b1;
         end
      end
   end

   // Sticky configuration error tracks the most recent load only
   always_ff @(posedge CLK or negedge HRESET) begin
      if (!HRESET) begin
         cfg_err <= 1'b0;
      end else if (div_load) begin
         cfg_err <= (div_int < DIV_MIN);
      end
   end

   // Cycle counter, fraction accumulator and oversample counter
   always_ff @(posedge CLK or negedge HRESET) begin
      if (!HRESET) begin
         cnt    <= '0;
         acc    <= '0;
         carry  <= 1'b0;
         os_cnt <= '0;
      end else if (restart) begin
         cnt    <= '0;
         acc    <= '0;
         carry  <= 1'b0;
         os_cnt <= '0;
      end else if (wrap) begin
         cnt            <= '0;
         {carry, acc}   <= acc_sum;
         os_cnt         <= os_next;
      end else if (enable) begin
         cnt <= cnt + CNT_ONE;
      end
   end

   // Registered strobes and bit-rate square wave
   always_ff @(posedge CLK or negedge HRESET) begin
      if (!HRESET) begin
         os_tick  <= 1'b0;
         bit_tick <= 1'b0;
         div_clk  <= 1'b0;
      end else if (restart) begin
         os_tick  <= 1'b0;
         bit_tick <= 1'b0;
         div_clk  <= 1'b1;
      end else begin
         os_tick  <= wrap;
         bit_tick <= wrap && os_last;
         if (wrap) begin
            div_clk <= div_clk_next;
         end
      end
   end

endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
- Parametrised fractional baud-rate generator; successor to the simple toggling UART clock divider.
- Produces a single-cycle oversample strobe (os_tick) for the RX sampler and a bit strobe (bit_tick) for TX.
- Also produces a bit-rate square wave (div_clk) for legacy consumers.
- Divisor is integer plus fraction, double-buffered so updates land only on period boundaries; sits between the UART register file and the TX/RX engines.

Parameters:
- CNT_W, 16, width of the integer divisor and cycle counter.
- FRAC_W, 4, width of the fractional divisor; fraction = div_frac / 2^FRAC_W.
- OVS, 16, os_ticks per bit; legal range 4..16, must be even.

Ports:
- HRESET  in  1  asynchronous active-low reset
- CLK  in  1  system clock
- enable  in  1  run when 1; freeze all counters when 0
- div_int  in  CNT_W  integer part of the os_tick period, in CLK cycles
- div_frac  in  FRAC_W  fractional part of the os_tick period
- div_load  in  1  one-cycle pulse; capture div_int/div_frac into the pending register
- restart  in  1  synchronous phase reset of all counters
- os_tick  out  1  one-cycle oversample strobe
- bit_tick  out  1  one-cycle bit strobe, coincident with every OVS-th os_tick
- div_clk  out  1  bit-rate square wave
- cfg_err  out  1  sticky flag: last loaded div_int was < 2

Behaviour:
- Reset (HRESET low, asynchronous): os_tick=0, bit_tick=0, div_clk=0, cfg_err=0.
  - Cycle counter, fraction accumulator and os counter all reset to 0.
  - Active and pending divisor = {2, 0}; pending_valid=0.
- Effective integer divisor D = max(div_int_active, 2). Load of div_int < 2 sets cfg_err=1.
- cfg_err clears on the next load with div_int >= 2.
- Period length P = D + c cycles, where c is the carry of this period's fraction accumulation.
- Cycle counter: counts 0..P-1 while enable=1.
  - os_tick is registered: high for exactly one cycle, in the cycle after the counter value P-1.
  - With enable held high from counter=0, the first os_tick is seen P edges later.
- Fraction accumulator (FRAC_W bits) is updated at each period wrap: acc <= acc + div_frac_active.
  - The carry out becomes c for the next period.
  - Average os_tick period = D + div_frac/2^FRAC_W.
- os counter: 0..OVS-1, increments on each os_tick, wraps to 0.
  - bit_tick is asserted in the same cycle as the os_tick that moves the counter OVS-1 -> 0.
- div_clk: registered; 1 while the os counter is < OVS/2, else 0.
  - Updates in the cycle os_tick is asserted; 50% duty at bit rate.
- div_load captures the inputs into pending and sets pending_valid.
  - At the next period wrap, pending is copied to active and pending_valid is cleared.
  - The fraction accumulator is preserved; the new D takes effect for the following period.
  - If enable=0, pending is applied on the next cycle instead.
  - A second load before application overwrites pending; last load wins.
- restart: next cycle, cycle counter, acc and os counter are 0; os_tick/bit_tick are 0; div_clk=1.
  - A pending divisor is applied immediately.
  - restart has priority over counting and over div_load in the same cycle; the load is still captured and applied.
- enable=0: all counters hold and os_tick/bit_tick are forced 0; div_clk holds.
  - Re-enable resumes mid-period with no extra ticks.
- Counter width: the compare uses CNT_W-bit D; the counter never exceeds D, since the carry extends the period by one and D+1 must fit in CNT_W+1 internally.
  - div_int = 2^CNT_W-1 is legal.
- Reset mid-operation aborts the period with no tick emitted.

Test Plan:
- div_int=4, div_frac=0, OVS=16, load then enable -> os_tick every 4 cycles; bit_tick every 64 cycles.
  - div_clk high 32 / low 32 cycles.
- div_int=4, div_frac=8 (0.5) -> os_tick periods alternate 4,5; exactly 16 os_ticks in 72 cycles; bit_tick interval 72.
- Mid-period load div_int=6 while running at 4 -> current period completes at 4; all following periods are 6; no glitch tick.
- div_int=1 loaded -> cfg_err=1, os_tick period 2; then load div_int=3 -> cfg_err=0, period 3.
- Assert restart at os counter=9 -> os_tick/bit_tick low next cycle, div_clk=1; first bit_tick 64 cycles later (div 4).
- Drop HRESET mid-period, then enable=0 for 10 cycles -> all outputs 0 immediately on reset; while disabled, no ticks and counters frozen; resume completes the remaining cycles of the period.
